ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester arbiter in front of a shared single-port, synchronous-read RAM.
// One access is granted per cycle.  A granted read returns its data on the
// requesting port two cycles after the grant, as a one-cycle rvalid pulse.
//
// Build option:
//   ARB_FIXED_PRIORITY_EN  defined   -> req0 always wins a tie (fixed priority)
//                          undefined -> round-robin on the last granted port
// In both builds the last-grant state is tracked.
module ram_port_arbiter #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] din0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAST0 = 2'd1,
    LAST1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // A granted read heading into the RAM read cycle
  logic   rd_gnt;
  logic   vld_p0;
  logic   port_p0;

  // Last-grant state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant decision and next state; nothing is granted while reset is held
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
`ifdef ARB_FIXED_PRIORITY_EN
        gnt0 = 1'b1;
`else
        if (state == LAST0) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`endif
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      state_nxt = LAST0;
    end else if (gnt1) begin
      state_nxt = LAST1;
    end
  end

  // Stage 0 (grant cycle): steer the winner onto the RAM port, idle bus otherwise
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    rd_gnt   = 1'b0;
    if (gnt0) begin
      ram_addr = addr0;
      ram_din  = din0;
      ram_we   = we0;
      rd_gnt   = !we0;
    end else if (gnt1) begin
      ram_addr = addr1;
      ram_din  = din1;
      ram_we   = we1;
      rd_gnt   = !we1;
    end
  end

  // Stage 0 -> 1: remember which port owns the read now in the RAM
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      port_p0 <= 1'b0;
    end else begin
      vld_p0  <= rd_gnt;
      port_p0 <= gnt1;
    end
  end

  // Stage 1 -> 2: capture RAM data on the owning port and pulse its rvalid
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= vld_p0 && !port_p0;
      rvalid1 <= vld_p0 && port_p0;
      if (vld_p0 && !port_p0) begin
        rdata0 <= ram_dout;
      end
      if (vld_p0 && port_p0) begin
        rdata1 <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Bench for ram_port_arbiter: a behavioural RAM plus a transaction-level model
// (shadow memory, completion queue, last-winner integer) checked every cycle.
// Honours ARB_FIXED_PRIORITY_EN when it is defined for the build.
module tb_ram_port_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata0, rdata1, ram_din;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;

  ram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock(clock), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Shared single-port RAM with synchronous read
  logic [DW-1:0] mem [8] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
                             32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007};
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } cmp_t;

  logic [DW-1:0] smem [8] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
                              32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007};
  cmp_t          q[$];
  int            last_g = -1;
  int            win = -1;
  int            sc = 0;
  logic          erv0 = 1'b0, erv1 = 1'b0;
  logic [DW-1:0] erd0 = '0, erd1 = '0;
  logic [1:0]    obs_g;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check everything, advance the model over the edge
  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    cmp_t          e;
    req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
    win = -1;
    if (r0 && r1) win = (FIXED || last_g != 0) ? 0 : 1;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    ea = '0; ed = '0; ew = 1'b0;
    if (win == 0) begin ea = a0; ed = d0; ew = w0; end
    if (win == 1) begin ea = a1; ed = d1; ew = w1; end
    #1;
    obs_g = {gnt1, gnt0};
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("ram_we", ram_we, ew);
    chk("ram_addr", ram_addr, ea);
    chk("ram_din", ram_din, ed);
    chk("rvalid0", rvalid0, erv0);
    chk("rvalid1", rvalid1, erv1);
    chk("rdata0", rdata0, erd0);
    chk("rdata1", rdata1, erd1);
    if (win >= 0) begin
      if (ew) smem[ea] = ed;
      else    q.push_back('{win, smem[ea], sc + 2});
      last_g = win;
    end
    @(posedge clock);
    #1;
    sc++;
    erv0 = 1'b0;
    erv1 = 1'b0;
    if (q.size() > 0 && q[0].due == sc) begin
      e = q.pop_front();
      if (e.port == 0) begin erv0 = 1'b1; erd0 = e.data; end
      else             begin erv1 = 1'b1; erd1 = e.data; end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Assert reset mid-cycle, check the forced outputs, release after two edges
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_ram_din", ram_din, '0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_rdata0", rdata0, '0);
    chk("rst_rdata1", rdata1, '0);
    q.delete();
    last_g = -1;
    erv0 = 1'b0; erv1 = 1'b0;
    erd0 = '0;   erd1 = '0;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  logic [1:0]    pat [4];
  logic [DW-1:0] wv;
  logic          hr0, hw0, hr1, hw1;
  logic [AW-1:0] ha0, ha1;
  logic [DW-1:0] hd0, hd1;

  initial begin
    // power-on reset with both requests high: nothing may be granted
    req0 = 1'b1; req1 = 1'b1;
    reset_pulse();
    req0 = 1'b0; req1 = 1'b0;

    // write 0xA5A5A5A5 to addr 3 from port 0, read it back on port 1
    step(1'b1, 1'b1, 3'd3, 32'hA5A5_A5A5, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd3, '0);
    idle(2);
    chk("a5_rdata1", rdata1, 32'hA5A5_A5A5);
    idle(1);

    // both ports reading addr 1 / addr 2 for four cycles straight from reset
    reset_pulse();
    pat[0] = 2'b01;
    pat[1] = FIXED ? 2'b01 : 2'b10;
    pat[2] = 2'b01;
    pat[3] = FIXED ? 2'b01 : 2'b10;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 3'd1, '0, 1'b1, 1'b0, 3'd2, '0);
      chk("tie_pattern", obs_g, pat[i]);
    end
    idle(3);

    // read granted on port 0, reset the next cycle: the read must vanish
    step(1'b1, 1'b0, 3'd4, '0, 1'b0, 1'b0, '0, '0);
    req0 = 1'b1; req1 = 1'b1;
    reset_pulse();
    step(1'b1, 1'b0, 3'd6, '0, 1'b1, 1'b0, 3'd7, '0);
    chk("post_rst_tie", obs_g, 2'b01);
    idle(3);

    // port 1 read completes, then a port 0 read must leave rdata1 alone
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd7, '0);
    idle(2);
    step(1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0, '0);
    idle(3);
    chk("rdata1_hold", rdata1, smem[7]);

    // write then read the same address on consecutive cycles
    wv = $urandom;
    step(1'b1, 1'b1, 3'd5, wv, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd5, '0);
    idle(2);
    chk("raw_rdata1", rdata1, wv);
    idle(1);

    // random traffic: requests held until granted, junk fields while idle
    hr0 = 1'b0; hr1 = 1'b0;
    hw0 = 1'b0; hw1 = 1'b0; ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hr0 && $urandom_range(0, 9) < 6) begin
        hr0 = 1'b1; hw0 = 1'($urandom_range(0, 1)); ha0 = 3'($urandom_range(0, 7)); hd0 = $urandom;
      end
      if (!hr1 && $urandom_range(0, 9) < 6) begin
        hr1 = 1'b1; hw1 = 1'($urandom_range(0, 1)); ha1 = 3'($urandom_range(0, 7)); hd1 = $urandom;
      end
      step(hr0, hr0 ? hw0 : 1'($urandom_range(0, 1)), hr0 ? ha0 : 3'($urandom_range(0, 7)),
           hr0 ? hd0 : $urandom,
           hr1, hr1 ? hw1 : 1'($urandom_range(0, 1)), hr1 ? ha1 : 3'($urandom_range(0, 7)),
           hr1 ? hd1 : $urandom);
      if (win == 0) hr0 = 1'b0;
      if (win == 1) hr1 = 1'b0;
      if (i == 200) reset_pulse();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
